// File: rtl/vdac_sar_ctrl_if.sv
// Signal bundle between the SAR controller and its request/comparator side.
// Start and abort are level-sampled requests. o_valid is a one-cycle strobe with no ready; o_result is new on that cycle.
interface vdac_sar_ctrl_if #(
    parameter int BITWIDTH = 6
);
    logic                i_start;
    logic                i_abort;
    logic                i_comp;
    logic [BITWIDTH-1:0] o_dac_data;
    logic                o_dac_enable;
    logic                o_busy;
    logic                o_valid;
    logic [BITWIDTH-1:0] o_result;
    logic [1:0]          o_state;

    modport slave (
        input  i_start, i_abort, i_comp,
        output o_dac_data, o_dac_enable, o_busy, o_valid, o_result, o_state
    );

    modport master (
        output i_start, i_abort, i_comp,
        input  o_dac_data, o_dac_enable, o_busy, o_valid, o_result, o_state
    );
endinterface

// File: rtl/vdac_sar_ctrl.sv
// Successive-approximation sequencer for the temp-sensor vdac and external comparator.
// Each trial bit is held for SETTLE_CYCLES, then decided from the synchronised comparator.
module vdac_sar_ctrl #(
    parameter int BITWIDTH      = 6,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    vdac_sar_ctrl_if.slave    bus
);
    localparam int KW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [BITWIDTH-1:0] MSB_CODE = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [7:0]          CNT_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [KW-1:0]       K_TOP    = KW'(BITWIDTH - 1);

    logic [1:0]          state;
    logic [KW-1:0]       k;
    logic [7:0]          cnt;
    logic                comp_meta;
    logic                comp_s;
    logic [BITWIDTH-1:0] dac_data;
    logic                dac_enable;
    logic                busy;
    logic                valid;
    logic [BITWIDTH-1:0] result;
    logic [BITWIDTH-1:0] sample_code;

    // comp_s=1 means the trial is too high, so drop bit k; then arm the next lower bit.
    always_comb begin
        sample_code = dac_data;
        if (comp_s) begin
            sample_code[k] = 1'b0;
        end
        if (k != '0) begin
            sample_code[k - KW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            k          <= '0;
            cnt        <= '0;
            comp_meta  <= 1'b0;
            comp_s     <= 1'b0;
            dac_data   <= '0;
            dac_enable <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            result     <= '0;
        end else begin
            comp_meta <= bus.i_comp;
            comp_s    <= comp_meta;
            valid     <= 1'b0;
            if (bus.i_abort) begin
                state      <= ST_IDLE;
                k          <= '0;
                cnt        <= '0;
                dac_data   <= '0;
                dac_enable <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.i_start) begin
                            state      <= ST_SETTLE;
                            dac_data   <= MSB_CODE;
                            k          <= K_TOP;
                            cnt        <= '0;
                            busy       <= 1'b1;
                            dac_enable <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == CNT_LAST) begin
                            state <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        if (k != '0) begin
                            dac_data <= sample_code;
                            k        <= k - KW'(1);
                            cnt      <= '0;
                            state    <= ST_SETTLE;
                        end else begin
                            dac_data <= sample_code;
                            result   <= sample_code;
                            valid    <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        dac_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_dac_data   = dac_data;
    assign bus.o_dac_enable = dac_enable;
    assign bus.o_busy       = busy;
    assign bus.o_valid      = valid;
    assign bus.o_result     = result;
    assign bus.o_state      = state;
endmodule

// File: tb/tb_vdac_sar_ctrl.sv
// Bench for vdac_sar_ctrl: comparator model i_comp = (dac code > threshold), scoreboard of results.
module tb_vdac_sar_ctrl;
    localparam int W = 6;

    logic i_clk;
    logic i_rst_n;
    logic [W-1:0] thr;
    logic force_high;

    vdac_sar_ctrl_if #(.BITWIDTH(W)) bus ();

    vdac_sar_ctrl #(.BITWIDTH(W), .SETTLE_CYCLES(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    assign bus.i_comp = force_high | (bus.o_dac_data > thr);

    // clock / cycle counter
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int last_valid_cyc = -1;
    int busy_fall_cyc = -1;
    logic prev_busy = 1'b0;
    int c0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // output monitor: pops the scoreboard on every valid strobe
    always @(negedge i_clk) begin
        if (bus.o_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) check("sb_unexpected_valid", 1, 0);
            else check("sb_result", 32'(bus.o_result), 32'(exp_q.pop_front()));
        end
        if (prev_busy && bus.o_busy === 1'b0) busy_fall_cyc = cyc;
        prev_busy = bus.o_busy;
    end

    task automatic wait_cyc(input int target);
        do @(negedge i_clk); while (cyc < target);
    endtask

    // called at a negedge; E0 is the next posedge
    task automatic kick(input logic [W-1:0] t, input logic f, input bit expect_result);
        thr = t;
        force_high = f;
        bus.i_start = 1'b1;
        @(posedge i_clk);
        #1;
        c0 = cyc;
        if (expect_result) exp_q.push_back(f ? '0 : t);
        @(negedge i_clk);
        bus.i_start = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_dac"}, 32'(bus.o_dac_data), 0);
        check({tag, "_en"}, 32'(bus.o_dac_enable), 0);
        check({tag, "_busy"}, 32'(bus.o_busy), 0);
        check({tag, "_valid"}, 32'(bus.o_valid), 0);
        check({tag, "_state"}, 32'(bus.o_state), 0);
    endtask

    task automatic full_conv(input logic [W-1:0] t, input logic f, input string tag);
        int vc;
        vc = valid_cnt;
        kick(t, f, 1'b1);
        wait_cyc(c0 + 33);
        check({tag, "_nvalid"}, 32'(valid_cnt - vc), 1);
        check({tag, "_lat"}, 32'(last_valid_cyc - c0), 30);
        check({tag, "_busyfall"}, 32'(busy_fall_cyc - c0), 31);
        check({tag, "_hold"}, 32'(bus.o_result), 32'(f ? '0 : t));
    endtask

    logic [W-1:0] trial_tbl[6];
    int vc0;

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        trial_tbl = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37};
        i_rst_n = 1'b0;
        bus.i_start = 1'b1;
        bus.i_abort = 1'b0;
        thr = 6'd37;
        force_high = 1'b0;

        // reset held with start asserted
        repeat (3) begin
            @(negedge i_clk);
            check_idle_zero("rst");
            check("rst_result", 32'(bus.o_result), 0);
        end
        i_rst_n = 1'b1;
        bus.i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        check_idle_zero("post_rst");
        check("post_rst_result", 32'(bus.o_result), 0);

        // threshold 37: trial code sequence then completion timing
        vc0 = valid_cnt;
        kick(6'd37, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            wait_cyc(c0 + 5 * i + 2);
            check($sformatf("trial%0d", i), 32'(bus.o_dac_data), 32'(trial_tbl[i]));
            check($sformatf("trial%0d_en", i), 32'(bus.o_dac_enable), 1);
        end
        wait_cyc(c0 + 33);
        check("t37_nvalid", 32'(valid_cnt - vc0), 1);
        check("t37_lat", 32'(last_valid_cyc - c0), 30);
        check("t37_busyfall", 32'(busy_fall_cyc - c0), 31);
        check("t37_idle_dac_holds", 32'(bus.o_dac_data), 37);
        check("t37_idle_en", 32'(bus.o_dac_enable), 0);

        // extremes
        full_conv(6'd63, 1'b0, "t63");
        full_conv(6'd0, 1'b1, "force1");

        // start ignored mid-conversion and during DONE
        vc0 = valid_cnt;
        kick(6'd20, 1'b0, 1'b1);
        wait_cyc(c0 + 9);
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        wait_cyc(c0 + 30);
        check("done_state", 32'(bus.o_state), 3);
        check("done_busy", 32'(bus.o_busy), 1);
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        wait_cyc(c0 + 40);
        check("ign_nvalid", 32'(valid_cnt - vc0), 1);
        check("ign_lat", 32'(last_valid_cyc - c0), 30);
        check("ign_no_restart", 32'(bus.o_busy), 0);

        // back-to-back: start on the negedge where busy is first seen low
        vc0 = valid_cnt;
        kick(6'd10, 1'b0, 1'b1);
        wait_cyc(c0 + 31);
        check("b2b_busy_low", 32'(bus.o_busy), 0);
        begin
            int prev_c0;
            prev_c0 = c0;
            kick(6'd50, 1'b0, 1'b1);
            check("b2b_period", 32'(c0 - prev_c0), 32);
        end
        wait_cyc(c0 + 33);
        check("b2b_nvalid", 32'(valid_cnt - vc0), 2);
        check("b2b_lat", 32'(last_valid_cyc - c0), 30);
        check("b2b_result", 32'(bus.o_result), 50);

        // abort mid-conversion keeps previous result
        full_conv(6'd37, 1'b0, "pre_abort");
        vc0 = valid_cnt;
        kick(6'd20, 1'b0, 1'b0);
        wait_cyc(c0 + 16);
        bus.i_abort = 1'b1;
        @(negedge i_clk);
        bus.i_abort = 1'b0;
        check_idle_zero("abort");
        wait_cyc(c0 + 40);
        check("abort_nvalid", 32'(valid_cnt - vc0), 0);
        check("abort_result", 32'(bus.o_result), 37);

        // abort together with start in IDLE starts nothing
        bus.i_abort = 1'b1;
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        check_idle_zero("abort_start");
        repeat (3) @(negedge i_clk);
        check("abort_start_busy", 32'(bus.o_busy), 0);

        // reset mid-conversion clears result, then a fresh conversion
        vc0 = valid_cnt;
        kick(6'd40, 1'b0, 1'b0);
        wait_cyc(c0 + 11);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check_idle_zero("midrst");
        check("midrst_result", 32'(bus.o_result), 0);
        @(negedge i_clk);
        full_conv(6'd5, 1'b0, "t5");
        check("midrst_nvalid", 32'(valid_cnt - vc0), 1);

        check("sb_drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vdac_sar_ctrl.md
# vdac_sar_ctrl

Successive-approximation controller that sequences the temp-sensor voltage DAC (vdac) against an external comparator. It drives the DAC code and enable, waits a programmable settling time per trial bit, samples the synchronised comparator, and returns an N-bit result with a one-cycle valid strobe. It sits between the register/wishbone side of the temperature sensor and the analog vdac plus comparator.

## Interface
- BITWIDTH, 6: DAC and result width; must match the vdac BITWIDTH.
- SETTLE_CYCLES, 4: cycles the trial code is held before the comparator is sampled; legal range 3..255.
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_start  input  1  start request, sampled only in IDLE.
- i_abort  input  1  synchronous abort, effective in any state.
- i_comp  input  1  asynchronous comparator output; 1 means DAC voltage is above the sensed voltage.
- o_dac_data  output  BITWIDTH  code to vdac i_data. Treated as a monotonic offset-binary code: 0 is lowest and 2^BITWIDTH-1 is highest.
- o_dac_enable  output  1  to vdac i_enable.
- o_busy  output  1  conversion in progress.
- o_valid  output  1  one-cycle strobe; o_result is new.
- o_result  output  BITWIDTH  last completed conversion, held until the next completion.

## Operation
- i_comp passes through a 2-flop synchroniser (comp_s). SETTLE_CYCLES≥3 guarantees comp_s reflects the settled trial code.
- States: IDLE, SETTLE, SAMPLE, DONE. There is a bit index k running from BITWIDTH-1 down to 0, and a settle counter.
- IDLE:
  - o_busy=0, o_dac_enable=0.
  - o_dac_data holds its last value: 0 after reset or abort, otherwise the last result.
  - i_start=1 and i_abort=0 cause the following: state goes to SETTLE, o_dac_data becomes 1<<(BITWIDTH-1), k becomes BITWIDTH-1, the counter clears, o_busy goes to 1 and o_dac_enable goes to 1.
- SETTLE: the counter increments each cycle. When counter==SETTLE_CYCLES-1, the state goes to SAMPLE.
- SAMPLE, one cycle:
  - If comp_s=1, bit k of o_dac_data clears; otherwise it is kept.
  - If k>0, bit k-1 is set, k decrements, the counter clears, and the state goes to SETTLE.
  - If k==0, o_result takes the final code, o_valid goes to 1, and the state goes to DONE.
- DONE, one cycle: o_valid=1 and o_busy=1. i_start is ignored. The state goes to IDLE.
  - o_dac_data keeps the final code.
  - o_dac_enable drops on entering IDLE.
- i_start while in SETTLE, SAMPLE or DONE is ignored. It is not queued.
- i_abort=1 in any state: the next edge gives state=IDLE, o_dac_data=0, o_busy=0, o_dac_enable=0 and o_valid=0. o_result is unchanged and no strobe is issued.
  - Abort has priority over start.
  - Abort in the SAMPLE cycle of the last bit also suppresses the result.
- Reset (i_rst_n=0 at an edge):
  - state=IDLE.
  - o_dac_data, o_result, o_busy, o_valid, o_dac_enable, the counter, k and the synchroniser are all 0.
  - Reset mid-conversion behaves like abort, except that o_result is also cleared.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Edge E0 is the edge that samples i_start in IDLE. The first trial code appears after E0.
- Each bit takes SETTLE_CYCLES+1 cycles. Bit k is decided at edge E((BITWIDTH-k)·(SETTLE_CYCLES+1)).
- o_valid and the new o_result appear at edge E(BITWIDTH·(SETTLE_CYCLES+1)). For the defaults this is 30 cycles after E0.
- o_busy is high from E0 to E(BITWIDTH·(SETTLE_CYCLES+1)+1). This is 31 cycles for the defaults.
- The earliest next start is sampled at the edge after o_busy falls. Back-to-back conversions therefore have a period of BITWIDTH·(SETTLE_CYCLES+1)+2 cycles.
- The comparator synchroniser adds 2 cycles, and these fall within the settle window.

## Test plan
All tests use the defaults (BITWIDTH=6, SETTLE_CYCLES=4). The comparator model drives i_comp = (o_dac_data > threshold).
- Reset: hold i_rst_n=0 for 3 cycles with i_start=1. All outputs are 0 and the state stays IDLE. Release reset, with i_start low: outputs stay 0.
- Threshold=37 with a single start pulse:
  - Trial codes are 32, 48, 40, 36, 38, 37, each held for 5 cycles.
  - o_valid is high for exactly 1 cycle, 30 cycles after E0, with o_result=37.
  - o_busy falls 31 cycles after E0.
- Extremes: threshold=63 gives o_result=63. Forcing i_comp=1 throughout gives o_result=0. Both complete at cycle 30.
- Start ignored:
  - Pulse i_start at cycle 10 and again during DONE. There is no restart and exactly one o_valid.
  - A start one cycle after o_busy falls begins a new conversion, with o_valid 30 cycles later.
- Abort: convert threshold=37 to completion, then start threshold=20 and assert i_abort at cycle 17. The next cycle shows IDLE with o_dac_data=0, o_dac_enable=0 and o_busy=0. o_valid never pulses and o_result stays 37. Asserting i_abort together with i_start in IDLE starts nothing.
- Reset mid-conversion: assert i_rst_n=0 at cycle 12. All outputs are 0 on the next edge, including o_result. A fresh start then converts threshold=5 to 5.
